// File: rtl/monitoreo_pkg.sv
// Purpose: shared types, default thresholds and sample classifier for the temperature monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package monitoreo_pkg;

  // Per-channel FSM state codes, visible on estado_actual.
  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAJO   = 2'b01,
    ALTO   = 2'b10,
    ALERTA = 2'b11
  } estado_t;

  // Sample class. Prefixed so it can share the package with estado_t::NORMAL.
  typedef enum logic [1:0] {
    C_FRIO   = 2'b00,
    C_NORMAL = 2'b01,
    C_CALOR  = 2'b10
  } clase_t;

  // Side that raised the alert; decides heater vs fan while in ALERTA.
  typedef enum logic {
    LADO_FRIO  = 1'b0,
    LADO_CALOR = 1'b1
  } lado_t;

  localparam int T_BAJO_DEF = 180;
  localparam int T_ALTO_DEF = 260;

  // Raw classification, no hysteresis: cold below bajo, hot at or above alto.
  function automatic clase_t clasificar(input logic [31:0] t,
                                        input logic [31:0] bajo,
                                        input logic [31:0] alto);
    if (t < bajo)
      return C_FRIO;
    else if (t >= alto)
      return C_CALOR;
    else
      return C_NORMAL;
  endfunction

endpackage

// File: rtl/monitoreo_canal.sv
// Purpose: one temperature channel FSM (NORMAL/BAJO/ALTO/ALERTA) with persistence count and hysteresis.
// Latency: 1 clk from sampling edge to registered outputs.
// Backpressure: none; a sample is consumed in every cycle where valid=1.
// Ports: clk, arst_n; temp/valid/ack in; estado, contador, alerta, calefactor, ventilador out.
module monitoreo_canal
  import monitoreo_pkg::*;
#(
  parameter int TEMP_W     = 10,
  parameter int T_BAJO     = T_BAJO_DEF,
  parameter int T_ALTO     = T_ALTO_DEF,
  parameter int HYST       = 0,
  parameter int PERSIST    = 5,
  parameter int MODO_LATCH = 0,
  parameter int CNT_W      = $clog2(PERSIST + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [TEMP_W-1:0] temp,
  input  logic              valid,
  input  logic              ack,
  output logic [1:0]        estado,
  output logic [CNT_W-1:0]  contador,
  output logic              alerta,
  output logic              calefactor,
  output logic              ventilador
);

  localparam logic [31:0]      LIM_BAJO    = 32'(T_BAJO);
  localparam logic [31:0]      LIM_ALTO    = 32'(T_ALTO);
  localparam logic [31:0]      LIM_FRIO_H  = 32'(T_BAJO + HYST);
  localparam logic [31:0]      LIM_CALOR_H = 32'(T_ALTO - HYST);
  localparam logic [CNT_W-1:0] PERSIST_C   = CNT_W'(PERSIST);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lado_t            lado_q, lado_d, lado_ref;
  clase_t           ultima_q, ultima_d;
  clase_t           clase_raw, clase_ef, clase_act;
  logic [31:0]      t_ext;
  logic             en_banda_frio, en_banda_calor;

  always_comb begin
    t_ext     = 32'(temp);
    clase_raw = clasificar(t_ext, LIM_BAJO, LIM_ALTO);

    // A normal sample still inside the hysteresis band of the side we are on
    // is treated as that side for the exit decision (state/counter hold).
    en_banda_frio  = (clase_raw == C_NORMAL) && (t_ext < LIM_FRIO_H);
    en_banda_calor = (clase_raw == C_NORMAL) && (t_ext >= LIM_CALOR_H);
    lado_ref = (estado_q == BAJO) ? LADO_FRIO :
               (estado_q == ALTO) ? LADO_CALOR : lado_q;
    clase_ef = clase_raw;
    if (estado_q != NORMAL) begin
      if ((lado_ref == LADO_FRIO) && en_banda_frio)   clase_ef = C_FRIO;
      if ((lado_ref == LADO_CALOR) && en_banda_calor) clase_ef = C_CALOR;
    end

    // Class of the most recently accepted sample, including this cycle's.
    clase_act = valid ? clase_ef : ultima_q;

    estado_d = estado_q;
    cnt_d    = cnt_q;
    lado_d   = lado_q;
    ultima_d = ultima_q;

    if (valid) begin
      ultima_d = clase_ef;
      case (estado_q)
        NORMAL: begin
          if (clase_raw == C_FRIO) begin
            estado_d = BAJO;
            cnt_d    = CNT_W'(1);
          end else if (clase_raw == C_CALOR) begin
            estado_d = ALTO;
            cnt_d    = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        BAJO: begin
          if (clase_raw == C_FRIO) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == PERSIST_C) begin
              estado_d = ALERTA;
              lado_d   = LADO_FRIO;
            end
          end else if (clase_raw == C_CALOR) begin
            estado_d = ALTO;
            cnt_d    = CNT_W'(1);
          end else if (clase_ef == C_NORMAL) begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end
        end
        ALTO: begin
          if (clase_raw == C_CALOR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == PERSIST_C) begin
              estado_d = ALERTA;
              lado_d   = LADO_CALOR;
            end
          end else if (clase_raw == C_FRIO) begin
            estado_d = BAJO;
            cnt_d    = CNT_W'(1);
          end else if (clase_ef == C_NORMAL) begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end
        end
        default: begin // ALERTA
          cnt_d = PERSIST_C;
          if (clase_raw == C_FRIO && lado_q == LADO_CALOR) begin
            estado_d = BAJO;
            cnt_d    = CNT_W'(1);
          end else if (clase_raw == C_CALOR && lado_q == LADO_FRIO) begin
            estado_d = ALTO;
            cnt_d    = CNT_W'(1);
          end else if (clase_ef == C_NORMAL && MODO_LATCH == 0) begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end
        end
      endcase
    end

    // Latched alert clears only on ack once the channel has actually recovered.
    if ((MODO_LATCH != 0) && (estado_q == ALERTA) && ack && (clase_act == C_NORMAL)) begin
      estado_d = NORMAL;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado_q   <= NORMAL;
      cnt_q      <= '0;
      lado_q     <= LADO_FRIO;
      ultima_q   <= C_NORMAL;
      alerta     <= 1'b0;
      calefactor <= 1'b0;
      ventilador <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      lado_q     <= lado_d;
      ultima_q   <= ultima_d;
      alerta     <= (estado_d == ALERTA);
      calefactor <= (estado_d == BAJO) || ((estado_d == ALERTA) && (lado_d == LADO_FRIO));
      ventilador <= (estado_d == ALTO) || ((estado_d == ALERTA) && (lado_d == LADO_CALOR));
    end
  end

  assign estado   = estado_q;
  assign contador = cnt_q;

endmodule

// File: rtl/monitoreo_multicanal.sv
// Purpose: NUM_CH independent temperature monitors plus global alert summary.
// Latency: 1 clk sample-to-output per channel; alerta_global/canal_alerta combinational from alerta.
// Backpressure: none; every valid sample is consumed.
// Ports: clk, arst_n; temp_entrada/temp_valid/alerta_ack in; alerta, calefactor, ventilador,
//        estado_actual, contador_salida, alerta_global, canal_alerta out.
module monitoreo_multicanal
  import monitoreo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TEMP_W     = 10,
  parameter int T_BAJO     = T_BAJO_DEF,
  parameter int T_ALTO     = T_ALTO_DEF,
  parameter int HYST       = 0,
  parameter int PERSIST    = 5,
  parameter int MODO_LATCH = 0,
  parameter int CNT_W      = $clog2(PERSIST + 1)
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [NUM_CH*TEMP_W-1:0]   temp_entrada,
  input  logic [NUM_CH-1:0]          temp_valid,
  input  logic [NUM_CH-1:0]          alerta_ack,
  output logic [NUM_CH-1:0]          alerta,
  output logic [NUM_CH-1:0]          calefactor,
  output logic [NUM_CH-1:0]          ventilador,
  output logic [NUM_CH*2-1:0]        estado_actual,
  output logic [NUM_CH*CNT_W-1:0]    contador_salida,
  output logic                       alerta_global,
  output logic [$clog2(NUM_CH)-1:0]  canal_alerta
);

  localparam int SEL_W = $clog2(NUM_CH);

  if (PERSIST < 2 || (T_BAJO + HYST) > (T_ALTO - HYST)) begin : g_param_error
    $error("monitoreo_multicanal: need PERSIST>=2 and T_BAJO+HYST <= T_ALTO-HYST");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
    monitoreo_canal #(
      .TEMP_W     (TEMP_W),
      .T_BAJO     (T_BAJO),
      .T_ALTO     (T_ALTO),
      .HYST       (HYST),
      .PERSIST    (PERSIST),
      .MODO_LATCH (MODO_LATCH),
      .CNT_W      (CNT_W)
    ) u_canal (
      .clk        (clk),
      .arst_n     (arst_n),
      .temp       (temp_entrada[i*TEMP_W +: TEMP_W]),
      .valid      (temp_valid[i]),
      .ack        (alerta_ack[i]),
      .estado     (estado_actual[i*2 +: 2]),
      .contador   (contador_salida[i*CNT_W +: CNT_W]),
      .alerta     (alerta[i]),
      .calefactor (calefactor[i]),
      .ventilador (ventilador[i])
    );
  end

  assign alerta_global = |alerta;

  // Scan from the top down so the lowest alerting index is the last write.
  always_comb begin
    canal_alerta = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (alerta[i]) canal_alerta = SEL_W'(i);
    end
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Purpose: directed self-checking bench for monitoreo_multicanal (default, HYST=5 and latched instances).
// Latency: checks taken 1 time unit after the rising edge that registers each sample.
// Backpressure: n/a.
module tb_monitoreo_multicanal;

  logic clk;
  logic arst_n;

  logic [39:0] temp_d, temp_h, temp_l;
  logic [3:0]  valid_d, valid_h, valid_l;
  logic [3:0]  ack_d, ack_h, ack_l;

  logic [3:0]  alerta_d, cal_d, ven_d, alerta_h, cal_h, ven_h, alerta_l, cal_l, ven_l;
  logic [7:0]  est_d, est_h, est_l;
  logic [11:0] cnt_d, cnt_h, cnt_l;
  logic        glob_d, glob_h, glob_l;
  logic [1:0]  canal_d, canal_h, canal_l;

  int checks = 0;
  int errors = 0;

  monitoreo_multicanal dut (
    .clk(clk), .arst_n(arst_n), .temp_entrada(temp_d), .temp_valid(valid_d), .alerta_ack(ack_d),
    .alerta(alerta_d), .calefactor(cal_d), .ventilador(ven_d), .estado_actual(est_d),
    .contador_salida(cnt_d), .alerta_global(glob_d), .canal_alerta(canal_d));

  monitoreo_multicanal #(.HYST(5)) dut_h (
    .clk(clk), .arst_n(arst_n), .temp_entrada(temp_h), .temp_valid(valid_h), .alerta_ack(ack_h),
    .alerta(alerta_h), .calefactor(cal_h), .ventilador(ven_h), .estado_actual(est_h),
    .contador_salida(cnt_h), .alerta_global(glob_h), .canal_alerta(canal_h));

  monitoreo_multicanal #(.MODO_LATCH(1)) dut_l (
    .clk(clk), .arst_n(arst_n), .temp_entrada(temp_l), .temp_valid(valid_l), .alerta_ack(ack_l),
    .alerta(alerta_l), .calefactor(cal_l), .ventilador(ven_l), .estado_actual(est_l),
    .contador_salida(cnt_l), .alerta_global(glob_l), .canal_alerta(canal_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One valid sample on one channel of instance d (0=default, 1=HYST, 2=latch).
  task automatic muestra(input int d, input int ch, input int t);
    case (d)
      0: begin temp_d[ch*10 +: 10] = 10'(t); valid_d[ch] = 1'b1; end
      1: begin temp_h[ch*10 +: 10] = 10'(t); valid_h[ch] = 1'b1; end
      default: begin temp_l[ch*10 +: 10] = 10'(t); valid_l[ch] = 1'b1; end
    endcase
    @(posedge clk); #1;
    valid_d = '0; valid_h = '0; valid_l = '0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (est_d !== 8'h00) begin errors++; $display("FAIL reset_estado got %h exp 00", est_d); end
    checks++; if (cnt_d !== 12'h000) begin errors++; $display("FAIL reset_contador got %h exp 000", cnt_d); end
    checks++; if ({alerta_d, cal_d, ven_d, glob_d, canal_d} !== 15'd0) begin errors++;
      $display("FAIL reset_salidas got %h exp 0", {alerta_d, cal_d, ven_d, glob_d, canal_d}); end
    // Held reset must ignore a valid cold sample across an edge.
    temp_d[9:0] = 10'd150; valid_d[0] = 1'b1;
    @(posedge clk); #1;
    valid_d = '0;
    checks++; if (est_d[1:0] !== 2'b00) begin errors++; $display("FAIL reset_retenido got %b exp 00", est_d[1:0]); end
    arst_n = 1'b1;
  endtask

  task automatic test_alerta_frio();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      muestra(0, 0, 150);
      if (k < 5) begin
        checks++; if (est_d[1:0] !== 2'b01 || cnt_d[2:0] !== 3'(k) || alerta_d[0] !== 1'b0) begin errors++;
          $display("FAIL frio_paso%0d got est=%b cnt=%0d al=%b exp est=01 cnt=%0d al=0", k, est_d[1:0], cnt_d[2:0], alerta_d[0], k); end
      end
    end
    checks++; if (est_d[1:0] !== 2'b11 || cnt_d[2:0] !== 3'd5) begin errors++;
      $display("FAIL frio_alerta got est=%b cnt=%0d exp est=11 cnt=5", est_d[1:0], cnt_d[2:0]); end
    checks++; if (alerta_d !== 4'b0001 || cal_d !== 4'b0001 || ven_d !== 4'b0000) begin errors++;
      $display("FAIL frio_salidas got al=%b cal=%b ven=%b exp 0001 0001 0000", alerta_d, cal_d, ven_d); end
    checks++; if (glob_d !== 1'b1 || canal_d !== 2'd0) begin errors++;
      $display("FAIL frio_global got glob=%b canal=%0d exp 1 0", glob_d, canal_d); end
    // Non-latched: first normal sample clears the alert.
    muestra(0, 0, 220);
    checks++; if (est_d[1:0] !== 2'b00 || cnt_d[2:0] !== 3'd0 || glob_d !== 1'b0) begin errors++;
      $display("FAIL frio_salida_normal got est=%b cnt=%0d glob=%b exp 00 0 0", est_d[1:0], cnt_d[2:0], glob_d); end
  endtask

  task automatic test_calor_sin_alerta();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      muestra(0, 2, 300);
      checks++; if (est_d[5:4] !== 2'b10 || cnt_d[8:6] !== 3'(k) || ven_d[2] !== 1'b1) begin errors++;
        $display("FAIL calor_paso%0d got est=%b cnt=%0d ven=%b exp 10 %0d 1", k, est_d[5:4], cnt_d[8:6], ven_d[2], k); end
    end
    muestra(0, 2, 220);
    checks++; if (est_d[5:4] !== 2'b00 || cnt_d[8:6] !== 3'd0 || ven_d[2] !== 1'b0 || alerta_d !== 4'b0) begin errors++;
      $display("FAIL calor_fin got est=%b cnt=%0d ven=%b al=%b exp 00 0 0 0000", est_d[5:4], cnt_d[8:6], ven_d[2], alerta_d); end
  endtask

  task automatic test_umbrales();
    do_reset();
    muestra(0, 0, 179);
    checks++; if (est_d[1:0] !== 2'b01 || cnt_d[2:0] !== 3'd1) begin errors++;
      $display("FAIL umbral_179 got est=%b cnt=%0d exp 01 1", est_d[1:0], cnt_d[2:0]); end
    muestra(0, 0, 180);
    checks++; if (est_d[1:0] !== 2'b00 || cnt_d[2:0] !== 3'd0) begin errors++;
      $display("FAIL umbral_180 got est=%b cnt=%0d exp 00 0", est_d[1:0], cnt_d[2:0]); end
    muestra(0, 0, 259);
    checks++; if (est_d[1:0] !== 2'b00) begin errors++; $display("FAIL umbral_259 got est=%b exp 00", est_d[1:0]); end
    muestra(0, 0, 260);
    checks++; if (est_d[1:0] !== 2'b10 || cnt_d[2:0] !== 3'd1 || ven_d[0] !== 1'b1) begin errors++;
      $display("FAIL umbral_260 got est=%b cnt=%0d ven=%b exp 10 1 1", est_d[1:0], cnt_d[2:0], ven_d[0]); end
    muestra(0, 0, 100);
    checks++; if (est_d[1:0] !== 2'b01 || cnt_d[2:0] !== 3'd1 || cal_d[0] !== 1'b1 || ven_d[0] !== 1'b0) begin errors++;
      $display("FAIL alto_a_bajo got est=%b cnt=%0d cal=%b ven=%b exp 01 1 1 0", est_d[1:0], cnt_d[2:0], cal_d[0], ven_d[0]); end
    // HYST=5 instance: cold band [180,185), hot band [255,260).
    muestra(1, 0, 150);
    checks++; if (est_h[1:0] !== 2'b01 || cnt_h[2:0] !== 3'd1) begin errors++;
      $display("FAIL hyst_150 got est=%b cnt=%0d exp 01 1", est_h[1:0], cnt_h[2:0]); end
    muestra(1, 0, 182);
    checks++; if (est_h[1:0] !== 2'b01 || cnt_h[2:0] !== 3'd1) begin errors++;
      $display("FAIL hyst_182 got est=%b cnt=%0d exp 01 1", est_h[1:0], cnt_h[2:0]); end
    muestra(1, 0, 185);
    checks++; if (est_h[1:0] !== 2'b00 || cnt_h[2:0] !== 3'd0) begin errors++;
      $display("FAIL hyst_185 got est=%b cnt=%0d exp 00 0", est_h[1:0], cnt_h[2:0]); end
    muestra(1, 0, 300);
    muestra(1, 0, 256);
    checks++; if (est_h[1:0] !== 2'b10 || cnt_h[2:0] !== 3'd1) begin errors++;
      $display("FAIL hyst_256 got est=%b cnt=%0d exp 10 1", est_h[1:0], cnt_h[2:0]); end
    muestra(1, 0, 254);
    checks++; if (est_h[1:0] !== 2'b00 || cnt_h[2:0] !== 3'd0) begin errors++;
      $display("FAIL hyst_254 got est=%b cnt=%0d exp 00 0", est_h[1:0], cnt_h[2:0]); end
  endtask

  task automatic test_valid_huecos();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      muestra(0, 1, 150);
      // Sample value stays on the bus but valid is low: nothing may move.
      for (int g = 0; g < 2; g++) begin
        @(posedge clk); #1;
        checks++; if (cnt_d[5:3] !== 3'(k) || alerta_d[1] !== (k == 5)) begin errors++;
          $display("FAIL hueco_k%0d got cnt=%0d al=%b exp cnt=%0d al=%0d", k, cnt_d[5:3], alerta_d[1], k, (k == 5)); end
      end
      if (k == 4) begin
        checks++; if (est_d[3:2] !== 2'b01) begin errors++; $display("FAIL hueco_bajo got %b exp 01", est_d[3:2]); end
      end
    end
    checks++; if (est_d[3:2] !== 2'b11 || canal_d !== 2'd1) begin errors++;
      $display("FAIL hueco_alerta got est=%b canal=%0d exp 11 1", est_d[3:2], canal_d); end
  endtask

  task automatic test_latch();
    do_reset();
    for (int k = 0; k < 5; k++) muestra(2, 3, 150);
    checks++; if (est_l[7:6] !== 2'b11 || canal_l !== 2'd3) begin errors++;
      $display("FAIL latch_alerta got est=%b canal=%0d exp 11 3", est_l[7:6], canal_l); end
    // Ack while the last sample is still cold is ignored.
    ack_l[3] = 1'b1; @(posedge clk); #1; ack_l = '0;
    checks++; if (est_l[7:6] !== 2'b11) begin errors++; $display("FAIL latch_ack_frio got %b exp 11", est_l[7:6]); end
    muestra(2, 3, 220);
    checks++; if (est_l[7:6] !== 2'b11 || alerta_l[3] !== 1'b1 || cal_l[3] !== 1'b1 || cnt_l[11:9] !== 3'd5) begin errors++;
      $display("FAIL latch_retenida got est=%b al=%b cal=%b cnt=%0d exp 11 1 1 5", est_l[7:6], alerta_l[3], cal_l[3], cnt_l[11:9]); end
    ack_l[3] = 1'b1; @(posedge clk); #1; ack_l = '0;
    checks++; if (est_l[7:6] !== 2'b00 || alerta_l[3] !== 1'b0 || cnt_l[11:9] !== 3'd0 || glob_l !== 1'b0) begin errors++;
      $display("FAIL latch_ack got est=%b al=%b cnt=%0d glob=%b exp 00 0 0 0", est_l[7:6], alerta_l[3], cnt_l[11:9], glob_l); end
  endtask

  task automatic test_multi_y_reset();
    do_reset();
    for (int k = 0; k < 5; k++) muestra(0, 3, 150);
    checks++; if (canal_d !== 2'd3 || glob_d !== 1'b1) begin errors++;
      $display("FAIL multi_ch3 got canal=%0d glob=%b exp 3 1", canal_d, glob_d); end
    for (int k = 0; k < 5; k++) muestra(0, 1, 300);
    checks++; if (alerta_d !== 4'b1010 || canal_d !== 2'd1) begin errors++;
      $display("FAIL multi_prioridad got al=%b canal=%0d exp 1010 1", alerta_d, canal_d); end
    checks++; if (ven_d[1] !== 1'b1 || cal_d[1] !== 1'b0 || cal_d[3] !== 1'b1 || ven_d[3] !== 1'b0) begin errors++;
      $display("FAIL multi_lado got cal=%b ven=%b exp cal=1000 ven=0010", cal_d, ven_d); end
    for (int k = 0; k < 3; k++) muestra(0, 2, 150);
    checks++; if (cnt_d[8:6] !== 3'd3) begin errors++; $display("FAIL multi_cnt3 got %0d exp 3", cnt_d[8:6]); end
    // Mid-cycle async reset: outputs must clear before the next edge.
    arst_n = 1'b0;
    #1;
    checks++; if ({alerta_d, cal_d, ven_d, est_d, cnt_d, glob_d, canal_d} !== 43'd0) begin errors++;
      $display("FAIL reset_async got al=%b cal=%b ven=%b est=%h cnt=%h glob=%b canal=%0d exp all 0",
               alerta_d, cal_d, ven_d, est_d, cnt_d, glob_d, canal_d); end
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n  = 1'b0;
    temp_d  = '0; temp_h = '0; temp_l = '0;
    valid_d = '0; valid_h = '0; valid_l = '0;
    ack_d   = '0; ack_h = '0; ack_l = '0;
    test_reset();
    test_alerta_frio();
    test_calor_sin_alerta();
    test_umbrales();
    test_valid_huecos();
    test_latch();
    test_multi_y_reset();
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
